k_counter: RTL and testbench
============================

Name: k_counter

Overview:
- Loop filter ("K counter") of the DPLL; sits directly upstream of the increment/decrement counter.
- Integrates the phase-detector error and emits single-cycle carry/borrow pulses. These drive the ID counter's incIn/decIn inputs.
- Two independent modulo-K counters, one counting up-error and one counting down-error. K is programmable at run time.
- Also provides a lock indicator derived from the carry/borrow activity.

Parameters:
- CNT_W, 16: width of the up/down counters and of kMod.
- LOCK_W, 8: width of the quiet-cycle counter used for lock detection.
- LOCK_THRESH, 200: number of consecutive enabled cycles without carry or borrow required to assert locked. Must be < 2^LOCK_W.

Ports:
- clk  in  1  system clock (K clock, M*f0).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  phase-error valid. Counting occurs only when high (XOR/edge phase-detector output).
- dnUp  in  1  direction: 0 = count up counter, 1 = count down counter.
- kMod  in  CNT_W  modulus K. Values 0 and 1 are treated as 2.
- carry  out  1  one-cycle pulse, to ID counter incIn.
- borrow  out  1  one-cycle pulse, to ID counter decIn.
- upCnt  out  CNT_W  current up-counter value (debug).
- dnCnt  out  CNT_W  current down-counter value (debug).
- locked  out  1  lock indicator.

Behaviour:
- Reset (reset=0, asynchronous):
  - upCnt=0, dnCnt=0, carry=0, borrow=0, locked=0, quiet counter=0.
  - Takes effect immediately, mid-count included. No pulse is emitted while reset is low or in the first cycle after release unless enable causes one.
- Effective modulus: Keff = (kMod<2) ? 2 : kMod. kMod is sampled every cycle with no latching.
- Counting, all registered with 1-cycle latency from the enable/dnUp sample to the carry/borrow output:
  - enable=1, dnUp=0: if upCnt >= Keff-1 then upCnt<=0 and carry<=1; else upCnt<=upCnt+1, carry<=0.
  - enable=1, dnUp=1: same rule on dnCnt and borrow.
  - enable=0: both counters hold; carry=borrow=0.
- carry and borrow are never high in the same cycle. Each is high for exactly one clock.
- Since Keff>=2, consecutive pulses of the same kind are at least 2 cycles apart, so every pulse is consumable by the ID counter.
- Run-time K decrease: the ">=" compare means a counter already at or beyond the new Keff-1 wraps on its next count and emits one pulse. No counter ever exceeds 2^CNT_W-1 and no wrap is silently skipped.
- The idle counter never changes, whatever the other direction is doing.
- Lock detection:
  - quiet counter clears to 0 on any cycle where carry or borrow is asserted.
  - It increments on each enabled cycle without a pulse and saturates at LOCK_THRESH.
  - locked=1 when quiet==LOCK_THRESH, registered, so it rises the cycle after the threshold count is reached.
  - locked drops to 0 in the same cycle a carry or borrow output is asserted (combinational clear from pulse register).
  - enable=0 cycles neither increment nor clear quiet.

Optional Feature:
- Macro KCNT_CLEAR_OPPOSITE_EN selects the random-walk filter variant.
- Defined: when carry is generated, dnCnt is also cleared to 0 in the same update. When borrow is generated, upCnt is cleared. This is the random-walk filter: it needs K net-biased counts per correction and suppresses jitter.
- Not defined: the two counters are fully independent, per the rules above.

Test Plan:
- Reset: hold reset=0, toggle clock with enable=1, dnUp=0 -> all outputs 0. Release with kMod=4 -> after 4 enabled cycles carry pulses once (cycle 4 sample, visible cycle 5), upCnt returns to 0.
- Down path: kMod=3, enable=1, dnUp=1 for 9 cycles -> exactly 3 borrow pulses spaced 3 cycles apart, no carry, dnCnt sequence 1,2,0,1,2,0,...
- Clamp: kMod=0, enable=1, dnUp=0 for 6 cycles -> carry every 2nd cycle (3 pulses). kMod=1 gives the same result.
- K shrink: kMod=10, count up to upCnt=7, then set kMod=4 -> next enabled cycle carry=1, upCnt=0.
- Lock: LOCK_THRESH=200, kMod=1000, alternate dnUp each enabled cycle -> locked=1 after 200 quiet cycles. Then force a carry -> locked=0 in the carry cycle, quiet restarts from 0.
- Async reset mid-count: upCnt=5, assert reset between clock edges -> upCnt, carry, locked go to 0 immediately without a clock edge. With KCNT_CLEAR_OPPOSITE_EN defined: dnCnt=2, then an up carry -> dnCnt=0 on the same edge.

Source files
------------

// File: rtl/k_counter_if.sv
// Loop-filter bus: phase-error inputs from the detector, carry/borrow and status
// out to the ID counter.
interface k_counter_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             dnUp;
    logic [CNT_W-1:0] kMod;
    logic             carry;
    logic             borrow;
    logic [CNT_W-1:0] upCnt;
    logic [CNT_W-1:0] dnCnt;
    logic             locked;

    modport master (
        output enable, dnUp, kMod,
        input  carry, borrow, upCnt, dnCnt, locked
    );

    modport slave (
        input  enable, dnUp, kMod,
        output carry, borrow, upCnt, dnCnt, locked
    );
endinterface

// File: rtl/k_counter.sv
// DPLL K counter: twin modulo-K error integrators with carry/borrow pulses and lock detect.
// Optional KCNT_CLEAR_OPPOSITE_EN: a pulse also clears the opposite counter (random-walk filter).
module k_counter #(
    parameter int CNT_W       = 16,
    parameter int LOCK_W      = 8,
    parameter int LOCK_THRESH = 200
) (
    input  logic        clk,
    input  logic        reset,
    k_counter_if.slave  bus
);
    localparam logic [LOCK_W-1:0] LP_THRESH = LOCK_W'(LOCK_THRESH);

    logic [CNT_W-1:0]  r_up;
    logic [CNT_W-1:0]  r_dn;
    logic              r_carry;
    logic              r_borrow;
    logic [LOCK_W-1:0] r_quiet;
    logic              r_locked;

    logic [CNT_W-1:0]  w_keff_m1;
    logic              w_up_cnt;
    logic              w_dn_cnt;
    logic              w_carry_nxt;
    logic              w_borrow_nxt;

    // ">=" rather than "==" so a run-time K decrease never skips a wrap
    always_comb begin
        w_keff_m1    = (bus.kMod < CNT_W'(2)) ? CNT_W'(1) : bus.kMod - CNT_W'(1);
        w_up_cnt     = bus.enable && !bus.dnUp;
        w_dn_cnt     = bus.enable &&  bus.dnUp;
        w_carry_nxt  = w_up_cnt && (r_up >= w_keff_m1);
        w_borrow_nxt = w_dn_cnt && (r_dn >= w_keff_m1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_up     <= '0;
            r_dn     <= '0;
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
            r_quiet  <= '0;
            r_locked <= 1'b0;
        end else begin
            r_carry  <= w_carry_nxt;
            r_borrow <= w_borrow_nxt;

            if (w_up_cnt)
                r_up <= w_carry_nxt ? '0 : r_up + CNT_W'(1);
`ifdef KCNT_CLEAR_OPPOSITE_EN
            else if (w_borrow_nxt)
                r_up <= '0;
`endif

            if (w_dn_cnt)
                r_dn <= w_borrow_nxt ? '0 : r_dn + CNT_W'(1);
`ifdef KCNT_CLEAR_OPPOSITE_EN
            else if (w_carry_nxt)
                r_dn <= '0;
`endif

            // quiet is zero in the same cycle the pulse is visible
            if (w_carry_nxt || w_borrow_nxt)
                r_quiet <= '0;
            else if (bus.enable && (r_quiet != LP_THRESH))
                r_quiet <= r_quiet + LOCK_W'(1);

            r_locked <= (r_quiet == LP_THRESH);
        end
    end

    assign bus.carry  = r_carry;
    assign bus.borrow = r_borrow;
    assign bus.upCnt  = r_up;
    assign bus.dnCnt  = r_dn;
    assign bus.locked = r_locked & ~(r_carry | r_borrow);
endmodule

// File: tb/tb_k_counter.sv
// Bench for k_counter: directed scenarios plus randomized traffic against a cycle model.
module tb_k_counter;
    localparam int CNT_W  = 16;
    localparam int THRESH = 200;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    k_counter_if #(.CNT_W(CNT_W)) bus ();

    k_counter #(.CNT_W(CNT_W), .LOCK_W(8), .LOCK_THRESH(THRESH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference state
    int m_up, m_dn, m_quiet;
    bit m_carry, m_borrow, m_lockr;

    function automatic bit m_locked();
        return m_lockr && !m_carry && !m_borrow;
    endfunction

    task automatic model_reset();
        m_up = 0; m_dn = 0; m_quiet = 0;
        m_carry = 0; m_borrow = 0; m_lockr = 0;
    endtask

    // drive one cycle, advance the model across the edge, settle 1ns after it
    task automatic tick(input bit en, input bit dn, input int k);
        int  keff;
        bit  pc, pb;
        int  kk;
        logic [CNT_W-1:0] kv;
        kk = k;
        kv = kk[CNT_W-1:0];
        bus.enable = en;
        bus.dnUp   = dn;
        bus.kMod   = kv;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            keff = (int'(kv) < 2) ? 2 : int'(kv);
            pc = en && !dn && (m_up >= keff - 1);
            pb = en &&  dn && (m_dn >= keff - 1);
            m_lockr = (m_quiet == THRESH);
            if (en && !dn) m_up = pc ? 0 : m_up + 1;
            if (en &&  dn) m_dn = pb ? 0 : m_dn + 1;
`ifdef KCNT_CLEAR_OPPOSITE_EN
            if (pc) m_dn = 0;
            if (pb) m_up = 0;
`endif
            if (pc || pb) m_quiet = 0;
            else if (en && m_quiet < THRESH) m_quiet = m_quiet + 1;
            m_carry  = pc;
            m_borrow = pb;
        end
        #1;
    endtask

    task automatic apply_reset();
        #2 reset = 1'b0;
        #1 model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 4);
        total++;
        if (bus.carry !== 1'b0 || bus.borrow !== 1'b0 || bus.upCnt !== '0 ||
            bus.dnCnt !== '0 || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: c=%b b=%b up=%0d dn=%0d lk=%b required all 0",
                     bus.carry, bus.borrow, bus.upCnt, bus.dnCnt, bus.locked);
        end
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 1'b0, 4);
            total++;
            if (bus.upCnt !== CNT_W'(i % 4) || bus.carry !== (i == 4)) begin
                bad++;
                $display("FAIL reset_release cyc%0d: up=%0d c=%b required up=%0d c=%b",
                         i, bus.upCnt, bus.carry, i % 4, (i == 4));
            end
        end
    endtask

    task automatic test_down_path();
        int nb, nc;
        apply_reset();
        nb = 0; nc = 0;
        for (int i = 1; i <= 9; i++) begin
            tick(1'b1, 1'b1, 3);
            nb += int'(bus.borrow);
            nc += int'(bus.carry);
            total++;
            if (bus.dnCnt !== CNT_W'(i % 3) || bus.borrow !== (i % 3 == 0)) begin
                bad++;
                $display("FAIL down_path cyc%0d: dn=%0d b=%b required dn=%0d b=%b",
                         i, bus.dnCnt, bus.borrow, i % 3, (i % 3 == 0));
            end
        end
        total++;
        if (nb != 3 || nc != 0) begin
            bad++;
            $display("FAIL down_path_count: borrows=%0d carries=%0d required 3 and 0", nb, nc);
        end
    endtask

    task automatic test_clamp();
        int nc;
        for (int k = 0; k <= 1; k++) begin
            apply_reset();
            nc = 0;
            for (int i = 1; i <= 6; i++) begin
                tick(1'b1, 1'b0, k);
                nc += int'(bus.carry);
                total++;
                if (bus.carry !== (i % 2 == 0)) begin
                    bad++;
                    $display("FAIL clamp k=%0d cyc%0d: c=%b required %b", k, i, bus.carry, (i % 2 == 0));
                end
            end
            total++;
            if (nc != 3) begin
                bad++;
                $display("FAIL clamp_count k=%0d: carries=%0d required 3", k, nc);
            end
        end
    endtask

    task automatic test_k_shrink();
        apply_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 10);
        total++;
        if (bus.upCnt !== CNT_W'(7) || bus.carry !== 1'b0) begin
            bad++;
            $display("FAIL shrink_pre: up=%0d c=%b required 7 0", bus.upCnt, bus.carry);
        end
        tick(1'b1, 1'b0, 4);
        total++;
        if (bus.upCnt !== '0 || bus.carry !== 1'b1) begin
            bad++;
            $display("FAIL shrink_wrap: up=%0d c=%b required 0 1", bus.upCnt, bus.carry);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 0; i < 205; i++) begin
            tick(1'b1, i[0], 1000);
            total++;
            if (bus.locked !== m_locked()) begin
                bad++;
                $display("FAIL lock_ramp cyc%0d: lk=%b required %b", i, bus.locked, m_locked());
            end
        end
        total++;
        if (bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_reached: lk=%b required 1", bus.locked);
        end
        tick(1'b1, 1'b0, 2);
        total++;
        if (bus.carry !== 1'b1 || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL lock_drop: c=%b lk=%b required 1 0", bus.carry, bus.locked);
        end
        for (int i = 0; i < 150; i++) begin
            tick(1'b1, 1'b1, 1000);
            total++;
            if (bus.locked !== 1'b0) begin
                bad++;
                $display("FAIL lock_restart cyc%0d: lk=%b required 0", i, bus.locked);
            end
        end
        for (int i = 0; i < 60; i++) tick(1'b1, 1'b1, 1000);
        total++;
        if (bus.locked !== 1'b1) begin
            bad++;
            $display("FAIL lock_relock: lk=%b required 1", bus.locked);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 10);
        #2 reset = 1'b0;
        #1;
        total++;
        if (bus.upCnt !== '0 || bus.carry !== 1'b0 || bus.locked !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: up=%0d c=%b lk=%b required 0 0 0",
                     bus.upCnt, bus.carry, bus.locked);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_clear_opposite();
        int exp_dn;
        apply_reset();
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b1, 5);
        tick(1'b1, 1'b0, 2);
        tick(1'b1, 1'b0, 2);
`ifdef KCNT_CLEAR_OPPOSITE_EN
        exp_dn = 0;
`else
        exp_dn = 2;
`endif
        total++;
        if (bus.carry !== 1'b1 || bus.dnCnt !== CNT_W'(exp_dn)) begin
            bad++;
            $display("FAIL clear_opposite: c=%b dn=%0d required 1 %0d", bus.carry, bus.dnCnt, exp_dn);
        end
    endtask

    task automatic test_random();
        int k;
        int ks[9] = '{0, 1, 2, 3, 4, 5, 6, 20, 300};
        apply_reset();
        k = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) k = ks[$urandom_range(0, 8)];
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, k);
            total++;
            if (bus.carry !== m_carry || bus.borrow !== m_borrow ||
                bus.upCnt !== CNT_W'(m_up) || bus.dnCnt !== CNT_W'(m_dn) ||
                bus.locked !== m_locked()) begin
                bad++;
                $display("FAIL random cyc%0d: c=%b b=%b up=%0d dn=%0d lk=%b required %b %b %0d %0d %b",
                         i, bus.carry, bus.borrow, bus.upCnt, bus.dnCnt, bus.locked,
                         m_carry, m_borrow, m_up, m_dn, m_locked());
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.dnUp   = 1'b0;
        bus.kMod   = '0;
        model_reset();
        #1;
        test_reset();
        test_down_path();
        test_clamp();
        test_k_shrink();
        test_lock();
        test_async_reset();
        test_clear_opposite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
